// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: the bit-level FSM state encoding,
//                default timing/buffer constants and a counter-width helper.
//                The transmit and receive paths both use this package.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int c_CLKS_PER_BIT = 868;
    // Transmit buffer depth in bytes (power of two, >= 2)
    localparam int c_FIFO_DEPTH   = 4;
    // Payload bits per frame
    localparam int c_DATA_BITS    = 8;

    // Bit-level frame state, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Bits needed to hold a count of 0..n-1 (at least one bit)
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Byte buffer for the UART transmitter. Power-of-two depth,
//                pointers wrap naturally. The full flag is registered from
//                the next occupancy so the upstream ready is glitch-free.
//                A push while full is dropped without touching any state.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = c_FIFO_DEPTH,
    parameter int WIDTH = c_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    logic [c_AW:0]    w_count_next;

    // Qualified handshakes: no push into a full buffer, no pop from an empty one
    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & (r_count != '0);

    // Next occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (c_AW + 1)'(1);
            2'b01:   w_count_next = r_count - (c_AW + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and the registered full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule : tx_fifo
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter with a small byte buffer. Frames are
//                start(0), 8 data bits LSB first, stop(1); each bit lasts
//                CLKS_PER_BIT clocks. Back-to-back bytes go out with no idle
//                gap between the stop bit and the next start bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = c_FIFO_DEPTH
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx_data,
    output logic       tx_busy
);

    localparam int                  c_CW       = counter_width(CLKS_PER_BIT);
    localparam logic [c_CW-1:0]     c_BIT_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          c_IDX_LAST = 3'(c_DATA_BITS - 1);
    localparam int                  c_OCC_W    = $clog2(FIFO_DEPTH) + 1;

    uart_state_t          r_state;
    logic [c_CW-1:0]      r_baud_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;

    logic [7:0]           w_fifo_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_OCC_W-1:0]   w_fifo_count;
    logic                 w_bit_end;
    logic                 w_pop;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_DATA_BITS)
    ) u_fifo (
        .clk     (clk_in),
        .rst     (reset),
        .i_push  (data_valid),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_bit_end = (r_baud_cnt == c_BIT_LAST);

    // A byte leaves the buffer when idle, or at the end of a stop bit so the
    // next start bit follows immediately
    assign w_pop = ~w_fifo_empty &
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    // Frame sequencer: state, baud counter, bit index, shifter and line driver
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CW'(1);
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CW'(1);
                    end
                end

                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_fifo_data;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CW'(1);
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_baud_cnt <= '0;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

    assign data_ready = ~w_fifo_full;
    assign tx_data    = r_tx;
    assign tx_busy    = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4). A frame-
//                level model predicts ready/busy/line each cycle from frame
//                start times; a line decoder rebuilds bytes and compares them
//                with the queue of accepted bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx_data;
    logic       tx_busy;

    always #5 clk_in = ~clk_in;

    uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy)
    );

    // ---------------- reference model (written at posedge only) ------------
    int         cyc = 0;
    logic [7:0] pend_q[$];      // accepted, not yet started
    logic [7:0] exp_bytes[$];   // every accepted byte, in order
    int         exp_skip_to = 0;
    int         rst_gen = 0;
    int         free_at = 0;    // first edge at which the line is free again
    int         cur_start = 0;
    logic [7:0] cur_byte = 8'h00;
    bit         model_valid = 1'b0;
    bit         exp_ready = 1'b1;
    bit         exp_busy = 1'b0;
    bit         exp_tx = 1'b1;

    // Frame-level model: a frame starts when a byte is waiting and the line
    // is free, then lasts 10*C edges; the buffer holds at most D waiting bytes
    always @(posedge clk_in) begin : model
        int occ;
        int b;
        bit do_pop;
        bit do_push;
        cyc++;
        if (reset) begin
            pend_q.delete();
            exp_skip_to = exp_bytes.size();
            rst_gen++;
            free_at = cyc;
            model_valid = 1'b1;
        end else begin
            occ     = pend_q.size();
            do_pop  = (occ > 0) && (cyc >= free_at);
            do_push = data_valid && (occ < D);
            if (do_pop) begin
                cur_byte  = pend_q.pop_front();
                cur_start = cyc;
                free_at   = cyc + 10 * C;
            end
            if (do_push) begin
                pend_q.push_back(data_in);
                exp_bytes.push_back(data_in);
            end
        end
        exp_ready = (pend_q.size() < D);
        exp_busy  = (pend_q.size() != 0) || (cyc < free_at);
        if (cyc < free_at) begin
            b = (cyc - cur_start) / C;
            if (b == 0)      exp_tx = 1'b0;
            else if (b <= 8) exp_tx = cur_byte[b-1];
            else             exp_tx = 1'b1;
        end else begin
            exp_tx = 1'b1;
        end
    end

    // ---------------- checker + line monitor (negedge only) ----------------
    int         checks = 0;
    int         errors = 0;
    bit         end_check = 1'b0;
    bit         end_done = 1'b0;
    bit         mon_active = 1'b0;
    int         mon_t = 0;
    int         mon_idx = 0;
    int         mon_gen = 0;
    logic [7:0] mon_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle output comparison and frame decoding from the serial line
    always @(negedge clk_in) begin : monitor
        int b;
        if (model_valid) begin
            check("data_ready", 32'(data_ready), 32'(exp_ready));
            check("tx_busy",    32'(tx_busy),    32'(exp_busy));
            check("tx_data",    32'(tx_data),    32'(exp_tx));

            if (mon_gen != rst_gen) begin
                mon_gen    = rst_gen;
                mon_active = 1'b0;
                mon_idx    = exp_skip_to;
            end

            if (!mon_active) begin
                if (tx_data === 1'b0) begin
                    mon_active = 1'b1;
                    mon_t      = 0;
                end
            end else begin
                mon_t++;
            end

            if (mon_active && (mon_t % C == C / 2)) begin
                b = mon_t / C;
                if (b >= 1 && b <= 8) begin
                    mon_byte[b-1] = tx_data;
                end else if (b == 9) begin
                    check("stop_bit", 32'(tx_data), 32'd1);
                    if (mon_idx >= exp_bytes.size()) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %0h expected none", mon_byte);
                    end else begin
                        check("frame_byte", 32'(mon_byte), 32'(exp_bytes[mon_idx]));
                        mon_idx++;
                    end
                    mon_active = 1'b0;
                end
            end

            if (end_check && !end_done) begin
                check("bytes_not_emitted", 32'(exp_bytes.size() - mon_idx), 32'd0);
                end_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [7:0] d, input bit r);
        @(negedge clk_in);
        data_valid = v;
        data_in    = d;
        reset      = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin : stimulus
        int pct;
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hC3;
        pct        = 20;

        // bytes offered during reset must be dropped
        for (int i = 0; i < 3; i++) step(1'b1, 8'h3C, 1'b1);

        // single frame 0x55 from idle
        step(1'b1, 8'h55, 1'b0);
        idle(50);

        // three back-to-back frames
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h80, 1'b0);
        idle(130);

        // valid held for six cycles: buffer fills, sixth byte ignored
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        idle(220);

        // reset during data bit 3 of 0xA5 with two bytes queued
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        idle(15);
        step(1'b0, 8'h00, 1'b1);
        idle(60);

        // push coinciding with the stop-end pop at occupancy 2, then fill up
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h62, 1'b0);
        step(1'b1, 8'h63, 1'b0);
        idle(38);
        step(1'b1, 8'h64, 1'b0);
        step(1'b1, 8'h65, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        step(1'b1, 8'h67, 1'b0);
        step(1'b1, 8'h68, 1'b0);
        idle(260);

        // randomized traffic with varying density and rare resets
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) pct = $urandom_range(5, 90);
            step(($urandom_range(0, 99) < pct), 8'($urandom), ($urandom_range(0, 599) == 0));
        end
        idle(260);

        end_check = 1'b1;
        repeat (3) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire
